// File: rtl/iob_regfile_2p_wr_arb.sv
// Round-robin arbiter sharing one register-file write port among N_REQ requesters.
// Supports burst lock via a last flag, and drives the write port from a one-cycle registered stage.
module iob_regfile_2p_wr_arb #(
    parameter int N_REQ   = 4,
    parameter int WADDR_W = 4,
    parameter int WDATA_W = 32,
    parameter int WSTRB_W = WDATA_W / 8,
    parameter int GRANT_W = $clog2(N_REQ)
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     arst_n_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ-1:0]         req_last_i,
    input  logic [N_REQ*WADDR_W-1:0] req_waddr_i,
    input  logic [N_REQ*WSTRB_W-1:0] req_wstrb_i,
    input  logic [N_REQ*WDATA_W-1:0] req_wdata_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     wen_o,
    output logic [WADDR_W-1:0]       waddr_o,
    output logic [WSTRB_W-1:0]       wstrb_o,
    output logic [WDATA_W-1:0]       wdata_o,
    output logic [GRANT_W-1:0]       grant_o,
    output logic                     busy_o
);
    localparam logic [0:0]         ST_IDLE  = 1'b0;
    localparam logic [0:0]         ST_BURST = 1'b1;
    localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(N_REQ - 1);

    logic [0:0]         state_q, state_d;
    logic [GRANT_W-1:0] ptr_q, ptr_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic               wen_q, wen_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
    logic [WDATA_W-1:0] wdata_q, wdata_d;

    logic [GRANT_W-1:0] cand, winner, sel;
    logic               found, accept;

    function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + GRANT_W'(1);
    endfunction

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every variable gets a default before any condition so no latch is inferred.
        found  = 1'b0;
        winner = ptr_q;
        cand   = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = next_idx(cand);
        end
    end

    assign sel = (state_q == ST_BURST) ? grant_q : winner;

    always_comb begin
        req_ready_o = '0;
        if (cke_i && arst_n_i) begin
            if (state_q == ST_BURST) req_ready_o[sel] = req_valid_i[sel];
            else                     req_ready_o[sel] = found;
        end
    end

    assign accept = |req_ready_o;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        wen_d   = accept;
        waddr_d = waddr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        if (accept) begin
            grant_d = sel;
            waddr_d = req_waddr_i[int'(sel)*WADDR_W +: WADDR_W];
            wstrb_d = req_wstrb_i[int'(sel)*WSTRB_W +: WSTRB_W];
            wdata_d = req_wdata_i[int'(sel)*WDATA_W +: WDATA_W];
            if (req_last_i[sel]) begin
                state_d = ST_IDLE;
                ptr_d   = next_idx(sel);
            end else begin
                state_d = ST_BURST;
            end
        end
    end

    // A low clock enable freezes everything, including wen, since the register file shares it.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (cke_i) begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end

    assign wen_o   = wen_q;
    assign waddr_o = waddr_q;
    assign wstrb_o = wstrb_q;
    assign wdata_o = wdata_q;
    assign grant_o = grant_q;
    assign busy_o  = (state_q == ST_BURST);

endmodule

// File: doc/iob_regfile_2p_wr_arb.md
# iob_regfile_2p_wr_arb

Round-robin write-port arbiter that lets `N_REQ` requesters share the single write port of a two-port register file. Each requester issues write beats (address, byte strobe, data) over a valid/ready handshake. A requester may hold the port for a multi-beat burst, delimited by a `last` flag. The block registers the granted beat and drives the register-file write port one cycle later. It sits between the requesters (CPU-side CSR writers, DMA, peripheral status updaters) and the register file's write-enable/request inputs.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `WADDR_W`, 4: write address width.
- `WDATA_W`, 32: write data width; multiple of 8.
- `WSTRB_W`, `WDATA_W/8`: byte strobe width.
- `GRANT_W`, `$clog2(N_REQ)`: grant index width.

- `clk_i` input 1: clock, rising edge.
- `cke_i` input 1: clock enable; low freezes all state.
- `arst_n_i` input 1: asynchronous reset, active-low.
- `req_valid_i` input `N_REQ`: per-requester beat valid.
- `req_last_i` input `N_REQ`: per-requester last-beat-of-burst flag.
- `req_waddr_i` input `N_REQ*WADDR_W`: packed addresses; requester k at `[k*WADDR_W+:WADDR_W]`.
- `req_wstrb_i` input `N_REQ*WSTRB_W`: packed strobes.
- `req_wdata_i` input `N_REQ*WDATA_W`: packed data.
- `req_ready_o` output `N_REQ`: per-requester beat accepted (one-hot or zero).
- `wen_o` output 1: register-file write enable.
- `waddr_o` output `WADDR_W`: register-file write address.
- `wstrb_o` output `WSTRB_W`: register-file write strobe.
- `wdata_o` output `WDATA_W`: register-file write data.
- `grant_o` output `GRANT_W`: index of the current or last owner.
- `busy_o` output 1: high while in BURST.

## Operation
- FSM has two states, IDLE and BURST. Round-robin pointer `ptr` (`GRANT_W` bits) holds the highest-priority index.
- IDLE:
  - Winner = first k with `req_valid_i[k]`, searching `ptr, ptr+1, …` modulo `N_REQ`.
  - `req_ready_o[winner]` asserts combinationally in the same cycle.
  - The beat is accepted. `grant_o` is set to the winner.
  - If `req_last_i[winner]` = 1: stay in IDLE and set `ptr` = winner+1 mod `N_REQ`.
  - Otherwise: go to BURST with owner = winner.
  - If no valid: no ready, no state change.
- BURST:
  - Only `req_ready_o[owner]` may assert, equal to `req_valid_i[owner]`. All other requesters are stalled.
  - An accepted beat with `last` = 1 returns the FSM to IDLE and sets `ptr` = owner+1.
  - There is no timeout. The owner may idle indefinitely mid-burst.
- Output stage:
  - An accepted beat loads `waddr_o`/`wstrb_o`/`wdata_o` from the winner's slice and sets `wen_o` = 1 on the next edge.
  - With no acceptance, `wen_o` = 0. Address, strobe and data hold their last values.
- Strobe and address are passed through unmodified. Byte-lane address reconstruction stays in the register file.
- `cke_i` = 0: `req_ready_o` is forced to 0 and all registers hold.
  - `wen_o` keeps its value. The register file shares `cke_i`, so no duplicate write occurs.
- `req_ready_o` never depends on `req_ready_o`. No combinational loop exists through the requesters.
- `req_valid_i` must stay high and the payload stable until ready. The arbiter does not check this.

## Timing
- Reset (`arst_n_i` low, asynchronous) sets:
  - State IDLE, `ptr` = 0, `grant_o` = 0.
  - `wen_o`, `waddr_o`, `wstrb_o`, `wdata_o`, `busy_o` = 0.
  - `req_ready_o` = 0 while reset is asserted.
- Acceptance latency is 0 cycles from valid in IDLE. Write latency is 1 cycle: the beat accepted at edge t appears as `wen_o` in cycle t+1.
- Throughput is one beat per cycle, including back-to-back single beats from different requesters.
- `busy_o` is registered: high from the cycle after a non-last first beat until the cycle after the last beat.
- Reset mid-burst aborts the burst. The beat in the output stage is dropped (`wen_o` = 0).
- A single-requester system (`N_REQ` = 2, only one active) gets one beat per cycle with no bubbles.

## Test plan
- **Reset values:** assert `arst_n_i` low mid-cycle. All outputs go to 0 immediately, with no clock required.
- **Priority from reset:** `N_REQ`=4, all valid single beats (last=1), addresses 1..4. Grants go 0,1,2,3,0. Each requester's address appears on `waddr_o` one cycle after its ready, with `wen_o` continuously high.
- **Burst lock:**
  - Stimulus: requester 2 sends 3 beats (last on beat 3) while requester 0 is valid throughout.
  - Required: `req_ready_o[0]` = 0 for 3 cycles, `busy_o` high 2 cycles.
  - Required: requester 0 is granted on the 4th cycle; `ptr` = 3 afterwards.
- **Owner idle mid-burst:** requester 1 drops valid for 5 cycles mid-burst. No grants, `wen_o` = 0 for those cycles, and the burst resumes afterwards.
- **Clock enable:**
  - Stimulus: `cke_i` = 0 for 2 cycles with requests pending.
  - Required: `req_ready_o` = 0, no state change, and the beat and grant order resume unchanged.
- **Data/strobe integrity:** requester 3 writes `wstrb`=4'b0100, `wdata`=32'hA5A5_1234. The same values appear on `wstrb_o`/`wdata_o` at t+1.
